// File: rtl/wb_regfile.sv
// Write-back stage and integer register file: selects the write-back value, commits it to
// the architectural registers and serves two decode read ports with same-cycle bypass.
module wb_regfile #(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mem_to_reg,
  input  logic            reg_write_en,
  input  logic [XLEN-1:0] data,
  input  logic [XLEN-1:0] alu_out,
  input  logic [4:0]      rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic [XLEN-1:0] read_data1,
  output logic [XLEN-1:0] read_data2,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_valid,
  output logic [63:0]     write_count
);

  logic [XLEN-1:0] r_regs [NREG];
  logic [63:0]     r_write_count;
  logic            w_commit;
  logic [XLEN-1:0] w_wb_data;

  assign w_wb_data = mem_to_reg ? data : alu_out;
  // x0 is hardwired: a commit aimed at it is silently dropped.
  assign w_commit  = reg_write_en && (rd != 5'd0);

  assign wb_data     = w_wb_data;
  assign wb_valid    = w_commit && !reset;
  assign write_count = r_write_count;

  // Reset wins over a simultaneous commit; the lost commit is not counted either.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the whole array is cleared on reset so no read can ever return X; this keeps
      // the file in flops, which is what zero-on-reset architectural state requires.
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
      r_write_count <= '0;
    end else if (w_commit) begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples
      // the pre-edge values and the update order inside this block cannot matter.
      r_regs[rd]    <= w_wb_data;
      r_write_count <= r_write_count + 64'd1;
    end
  end

  function automatic logic [XLEN-1:0] read_port(
    input logic            rst,
    input logic [4:0]      rs,
    input logic            bypass_ok,
    input logic [4:0]      wr_idx,
    input logic [XLEN-1:0] wr_val,
    input logic [XLEN-1:0] stored
  );
    if (rst || rs == 5'd0) begin
      return '0;
    end else if (bypass_ok && wr_idx == rs) begin
      return wr_val;
    end
    return stored;
  endfunction

  // Bypass makes a write committed at the coming edge visible to decode in this cycle.
  always_comb begin
    read_data1 = read_port(reset, rs1, wb_valid, rd, w_wb_data, r_regs[rs1]);
    read_data2 = read_port(reset, rs2, wb_valid, rd, w_wb_data, r_regs[rs2]);
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and integer register file for the 5-stage pipeline. Consumes the MEM/WB pipeline register outputs: selects memory data or ALU result and commits it to one of 32 64-bit architectural registers. Serves the two decode-stage read ports, with a write-through bypass so a same-cycle write is visible to decode. Exports the write-back value for EX forwarding and a running count of committed register writes.

## Interface
Parameters:
- XLEN, 64, data width of registers and write-back path
- NREG, 32, number of architectural registers; index width fixed at 5 bits

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; sampled on rising edge of clk
- mem_to_reg  input  1  from MEM/WB: 1 selects data, 0 selects alu_out
- reg_write_en  input  1  from MEM/WB: commit request for this cycle
- data  input  XLEN  from MEM/WB: load data
- alu_out  input  XLEN  from MEM/WB: ALU result
- rd  input  5  from MEM/WB: destination register index
- rs1  input  5  decode read index, port 1
- rs2  input  5  decode read index, port 2
- read_data1  output  XLEN  register value for rs1 (combinational)
- read_data2  output  XLEN  register value for rs2 (combinational)
- wb_data  output  XLEN  selected write-back value (combinational), to forwarding unit
- wb_valid  output  1  reg_write_en && rd != 0 && !reset (combinational)
- write_count  output  64  number of committed writes since reset (registered)

## Operation
- wb_data = mem_to_reg ? data : alu_out, regardless of reg_write_en.
- Commit: on rising edge with reset=0, reg_write_en=1, rd!=0 → regs[rd] <= wb_data; write_count <= write_count + 1.
- x0: never written. A commit request with rd=0 is dropped: no state change, write_count unchanged, wb_valid=0.
- Read port n (rsn = rs1 or rs2), priority order:
  - reset=1 → 0
  - rsn=0 → 0
  - wb_valid=1 and rd=rsn → wb_data (bypass)
  - otherwise → regs[rsn]
- Both read ports are independent; rs1=rs2 is legal and returns identical values.
- write_count is 64-bit, wraps from 2^64-1 to 0 with no flag.
- Reset: on rising edge with reset=1, all regs[1..31] <= 0, write_count <= 0. Reset takes priority over a simultaneous commit; that commit is lost. Reset is not held across cycles; the cycle after deassertion operates normally.
- No X propagation: all registers have defined reset values. Reads of unwritten registers return 0 after reset.

## Timing
- Write latency: value committed at edge N is in regs from edge N onward; same-cycle read (before edge N) already returns it via bypass.
- Read ports, wb_data, and wb_valid are purely combinational from inputs and current state; zero-cycle latency.
- write_count updates one edge after the commit request is presented.
- Reset values of outputs: read_data1/2 = 0, wb_valid = 0, write_count = 0. wb_data follows inputs even in reset.
- No handshake or backpressure: one commit per cycle maximum, accepted unconditionally.

## Test plan
- Reset → all 32 registers read 0 on both ports; write_count=0; wb_valid=0 while reset high.
- Commit rd=5, alu_out=0x1234, mem_to_reg=0; then mem_to_reg=1, data=0xDEAD_BEEF, rd=6 → rs1=5 reads 0x1234, rs2=6 reads 0xDEADBEEF; write_count=2.
- Bypass: reg_write_en=1, rd=7, alu_out=0xAA, rs1=rs2=7 in same cycle → read_data1=read_data2=0xAA before the edge; old regs[7] not visible.
- x0: reg_write_en=1, rd=0, alu_out=0xFFFF → rs1=0 reads 0 same cycle and after; wb_valid=0; write_count unchanged.
- Reset mid-operation: reset=1 with reg_write_en=1, rd=3, alu_out=0x55 in same cycle → regs[3]=0 afterwards, write_count=0; next cycle's commit behaves normally.
- Back-to-back commits to rd=9 (0x1, 0x2, 0x3) over three cycles → reading rs1=9 each cycle returns the in-flight value; final regs[9]=0x3, write_count incremented by 3.
